// File: rtl/ball_motion_engine.sv
// Ball position/heading engine for the ping-pong playfield: 16-heading stepping,
// wall reflection, left/right miss detection. `BALL_SPEEDUP_EN adds speed-up on paddle hits.
module ball_motion_engine #(
    parameter int COORD_W   = 13,
    parameter int FRAC_BITS = 2,
    parameter int SPEED_W   = 3,
    parameter int X_MIN     = 10,
    parameter int X_MAX     = 630,
    parameter int Y_MIN     = 10,
    parameter int Y_MAX     = 470
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               move,
    input  logic               serve,
    input  logic [3:0]         serve_dir,
    input  logic [SPEED_W-1:0] speed_in,
    input  logic               dir_load,
    input  logic [3:0]         dir_in,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    output logic [3:0]         dir_out,
    output logic               in_play,
    output logic               bounce,
    output logic               miss_l,
    output logic               miss_r
);
    localparam int CW = COORD_W + 2;
    localparam logic [COORD_W-1:0] X_CTR = COORD_W'(((X_MIN + X_MAX) / 2) << FRAC_BITS);
    localparam logic [COORD_W-1:0] Y_CTR = COORD_W'(((Y_MIN + Y_MAX) / 2) << FRAC_BITS);
    localparam logic signed [CW-1:0] XL = CW'(X_MIN << FRAC_BITS);
    localparam logic signed [CW-1:0] XH = CW'(X_MAX << FRAC_BITS);
    localparam logic signed [CW-1:0] YL = CW'(Y_MIN << FRAC_BITS);
    localparam logic signed [CW-1:0] YH = CW'(Y_MAX << FRAC_BITS);
    localparam logic [SPEED_W-1:0] SPD_MAX = {SPEED_W{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OUT} state_t;

    state_t              r_state, w_state_next;
    logic [COORD_W-1:0]  r_x, r_y;
    logic [3:0]          r_dir;
    logic [SPEED_W-1:0]  r_speed;
    logic                r_bounce, r_miss_l, r_miss_r;

    logic [3:0]          w_head;
    logic signed [3:0]   w_dx4, w_dy4;
    logic signed [CW-1:0] w_spd, w_nx, w_ny, w_ny_clamp;
    logic                w_x_lo, w_x_hi, w_y_lo, w_y_hi;

    always_comb begin
        w_head = dir_load ? dir_in : r_dir;
        w_dx4  = 4'sd0;
        w_dy4  = 4'sd0;
        case (w_head)
            4'd0:  begin w_dx4 =  4'sd0; w_dy4 = -4'sd4; end
            4'd1:  begin w_dx4 =  4'sd1; w_dy4 = -4'sd3; end
            4'd2:  begin w_dx4 =  4'sd2; w_dy4 = -4'sd2; end
            4'd3:  begin w_dx4 =  4'sd3; w_dy4 = -4'sd1; end
            4'd4:  begin w_dx4 =  4'sd4; w_dy4 =  4'sd0; end
            4'd5:  begin w_dx4 =  4'sd3; w_dy4 =  4'sd1; end
            4'd6:  begin w_dx4 =  4'sd2; w_dy4 =  4'sd2; end
            4'd7:  begin w_dx4 =  4'sd1; w_dy4 =  4'sd3; end
            4'd8:  begin w_dx4 =  4'sd0; w_dy4 =  4'sd4; end
            4'd9:  begin w_dx4 = -4'sd1; w_dy4 =  4'sd3; end
            4'd10: begin w_dx4 = -4'sd2; w_dy4 =  4'sd2; end
            4'd11: begin w_dx4 = -4'sd3; w_dy4 =  4'sd1; end
            4'd12: begin w_dx4 = -4'sd4; w_dy4 =  4'sd0; end
            4'd13: begin w_dx4 = -4'sd3; w_dy4 = -4'sd1; end
            4'd14: begin w_dx4 = -4'sd2; w_dy4 = -4'sd2; end
            default: begin w_dx4 = -4'sd1; w_dy4 = -4'sd3; end
        endcase
        // Signed arithmetic with two guard bits so an underflow below zero reads as negative
        w_spd  = $signed({{(CW - SPEED_W){1'b0}}, r_speed});
        w_nx   = $signed({2'b00, r_x}) + CW'(w_dx4) * w_spd;
        w_ny   = $signed({2'b00, r_y}) + CW'(w_dy4) * w_spd;
        w_x_lo = (w_nx < XL);
        w_x_hi = (w_nx > XH);
        w_y_lo = (w_ny < YL);
        w_y_hi = (w_ny > YH);
        w_ny_clamp = w_y_lo ? YL : (w_y_hi ? YH : w_ny);

        w_state_next = r_state;
        if (serve)
            w_state_next = S_PLAY;
        else if (r_state == S_PLAY && move && (w_x_lo || w_x_hi))
            w_state_next = S_OUT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_x      <= X_CTR;
            r_y      <= Y_CTR;
            r_dir    <= 4'd0;
            r_speed  <= '0;
            r_bounce <= 1'b0;
            r_miss_l <= 1'b0;
            r_miss_r <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_bounce <= 1'b0;
            r_miss_l <= 1'b0;
            r_miss_r <= 1'b0;
            if (serve) begin
                r_x     <= X_CTR;
                r_y     <= Y_CTR;
                r_dir   <= serve_dir;
                r_speed <= speed_in;
            end else if (r_state == S_PLAY) begin
                if (move) begin
                    r_dir <= w_head;
                    if (w_x_lo || w_x_hi) begin
                        // Miss wins over a simultaneous wall hit: no reflection this step
                        r_x      <= w_x_lo ? XL[COORD_W-1:0] : XH[COORD_W-1:0];
                        r_y      <= w_ny_clamp[COORD_W-1:0];
                        r_miss_l <= w_x_lo;
                        r_miss_r <= w_x_hi;
                    end else begin
                        r_x <= w_nx[COORD_W-1:0];
                        r_y <= w_ny_clamp[COORD_W-1:0];
                        if (w_y_lo || w_y_hi) begin
                            r_dir    <= 4'd8 - w_head;
                            r_bounce <= 1'b1;
                        end
                    end
                end else if (dir_load) begin
                    r_dir <= dir_in;
                end
`ifdef BALL_SPEEDUP_EN
                if (dir_load && r_speed != SPD_MAX)
                    r_speed <= r_speed + 1'b1;
`endif
            end
        end
    end

    assign x_out   = r_x;
    assign y_out   = r_y;
    assign dir_out = r_dir;
    assign in_play = (r_state == S_PLAY);
    assign bounce  = r_bounce;
    assign miss_l  = r_miss_l;
    assign miss_r  = r_miss_r;
endmodule

// File: tb/tb_ball_motion_engine.sv
// Directed bench for ball_motion_engine: reset, straight runs, wall bounce, miss,
// simultaneous-event priority and the optional speed-up behaviour.
module tb_ball_motion_engine;
    logic        clk = 1'b0;
    logic        rst, move, serve, dir_load;
    logic [3:0]  serve_dir, dir_in;
    logic [2:0]  speed_in;
    logic [12:0] x_out, y_out;
    logic [3:0]  dir_out;
    logic        in_play, bounce, miss_l, miss_r;

    int n_checks = 0;
    int n_fail   = 0;

    ball_motion_engine dut (
        .clk(clk), .rst(rst), .move(move), .serve(serve), .serve_dir(serve_dir),
        .speed_in(speed_in), .dir_load(dir_load), .dir_in(dir_in),
        .x_out(x_out), .y_out(y_out), .dir_out(dir_out), .in_play(in_play),
        .bounce(bounce), .miss_l(miss_l), .miss_r(miss_r)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else
            $display("ok   %s: %0d", tag, obs);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_serve(input logic [3:0] d, input logic [2:0] s);
        serve = 1'b1; serve_dir = d; speed_in = s;
        tick();
        serve = 1'b0;
    endtask

    task automatic do_moves(input int n);
        move = 1'b1;
        repeat (n) tick();
        move = 1'b0;
    endtask

    int speedup_dx;

    initial begin
        rst = 1'b1; move = 1'b0; serve = 1'b0; dir_load = 1'b0;
        serve_dir = 4'd0; dir_in = 4'd0; speed_in = 3'd0;
        #1;
        repeat (2) tick();
        rst = 1'b0;
        check_eq("rst_x", x_out, 1280);
        check_eq("rst_y", y_out, 960);
        check_eq("rst_dir", dir_out, 0);
        check_eq("rst_in_play", in_play, 0);
        check_eq("rst_pulses", {bounce, miss_l, miss_r}, 0);

        // IDLE ignores move and dir_load
        dir_load = 1'b1; dir_in = 4'd5;
        do_moves(3);
        dir_load = 1'b0;
        check_eq("idle_x", x_out, 1280);
        check_eq("idle_dir", dir_out, 0);

        // straight right at speed 1
        do_serve(4'd4, 3'd1);
        check_eq("serve_in_play", in_play, 1);
        do_moves(10);
        check_eq("run_x", x_out, 1320);
        check_eq("run_y", y_out, 960);
        check_eq("run_pulses", {bounce, miss_l, miss_r}, 0);

        // top wall: 115 steps of 8 reach y=40 exactly, the 116th reflects
        do_serve(4'd0, 3'd2);
        do_moves(115);
        check_eq("top_y_at_bound", y_out, 40);
        check_eq("top_dir_before", dir_out, 0);
        check_eq("top_no_bounce", bounce, 0);
        do_moves(1);
        check_eq("top_y_clamp", y_out, 40);
        check_eq("top_dir_reflect", dir_out, 8);
        check_eq("top_bounce", bounce, 1);
        tick();
        check_eq("top_bounce_clear", bounce, 0);
        do_moves(1);
        check_eq("top_y_after", y_out, 48);

        // right miss at speed 4
        do_serve(4'd4, 3'd4);
        do_moves(77);
        check_eq("miss_x_at_bound", x_out, 2512);
        check_eq("miss_no_pulse", miss_r, 0);
        do_moves(1);
        check_eq("miss_x_clamp", x_out, 2520);
        check_eq("miss_r_pulse", miss_r, 1);
        check_eq("miss_l_quiet", miss_l, 0);
        check_eq("miss_in_play", in_play, 0);
        tick();
        check_eq("miss_r_clear", miss_r, 0);
        do_moves(5);
        check_eq("out_x_frozen", x_out, 2520);
        do_serve(4'd4, 3'd1);
        check_eq("reserve_x", x_out, 1280);
        check_eq("reserve_in_play", in_play, 1);

        // move with dir_load uses the loaded heading
        move = 1'b1; dir_load = 1'b1; dir_in = 4'd12;
        tick();
        move = 1'b0; dir_load = 1'b0;
        check_eq("load_move_x", x_out, 1276);
        check_eq("load_move_dir", dir_out, 12);

        // serve wins over move in the same cycle
        move = 1'b1;
        do_serve(4'd4, 3'd1);
        move = 1'b0;
        check_eq("serve_move_x", x_out, 1280);
        check_eq("serve_move_dir", dir_out, 4);

        // dir_load alone in PLAY changes heading only
        dir_load = 1'b1; dir_in = 4'd6;
        tick();
        dir_load = 1'b0;
        check_eq("dirload_dir", dir_out, 6);
        check_eq("dirload_x", x_out, 1280);

        // speed 0 never moves
        do_serve(4'd5, 3'd0);
        do_moves(4);
        check_eq("speed0_x", x_out, 1280);
        check_eq("speed0_y", y_out, 960);

        // speed-up saturation
`ifdef BALL_SPEEDUP_EN
        speedup_dx = 28;
`else
        speedup_dx = 24;
`endif
        do_serve(4'd4, 3'd6);
        dir_load = 1'b1; dir_in = 4'd4;
        repeat (3) tick();
        dir_load = 1'b0;
        do_moves(1);
        check_eq("speedup_x", x_out, 32'(1280 + speedup_dx));

        // reset mid-rally
        do_moves(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_x", x_out, 1280);
        check_eq("midrst_in_play", in_play, 0);
        check_eq("midrst_dir", dir_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ball_motion_engine.md
Name: ball_motion_engine

Overview:
Parametrised ball motion engine for the VGA ping-pong playfield. Each `move` tick advances the ball position one step along one of 16 headings, scaled by a speed factor. Position is unsigned fixed-point with FRAC_BITS subpixel bits. Top/bottom walls reflect the ball; crossing a left/right boundary ends the rally and raises a miss event. Paddle logic sits outside and reloads the heading through `dir_load`; the block feeds the renderer and the score keeper.

Parameters:
COORD_W, 13, coordinate width in bits, including fraction bits
FRAC_BITS, 2, subpixel bits (1 px = 2^FRAC_BITS units)
SPEED_W, 3, speed factor width
X_MIN, 10, left bound in pixels
X_MAX, 630, right bound in pixels
Y_MIN, 10, top bound in pixels
Y_MAX, 470, bottom bound in pixels

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
move  in  1  step strobe, one step per high cycle
serve  in  1  recentre the ball and start a rally
serve_dir  in  4  heading used at serve
speed_in  in  SPEED_W  speed factor latched at serve
dir_load  in  1  overwrite the heading (paddle hit)
dir_in  in  4  new heading when dir_load is high
x_out  out  COORD_W  ball x, fixed-point
y_out  out  COORD_W  ball y, fixed-point
dir_out  out  4  current heading
in_play  out  1  high while the rally is live
bounce  out  1  one-cycle pulse on a wall reflection
miss_l  out  1  one-cycle pulse when the left bound is crossed
miss_r  out  1  one-cycle pulse when the right bound is crossed

Behaviour:
- Reset values:
  - x = ((X_MIN+X_MAX)/2) << FRAC_BITS, i.e. 1280.
  - y = ((Y_MIN+Y_MAX)/2) << FRAC_BITS, i.e. 960.
  - dir = 0, speed = 0, state IDLE, in_play = 0, all pulses 0.
- States:
  - IDLE: after reset, waits for serve.
  - PLAY: moves on strobe, in_play = 1.
  - OUT: after a miss, waits for serve.
- serve in any state:
  - Next cycle: position recentred, dir = serve_dir, speed = speed_in, state PLAY.
  - serve has priority over move and dir_load in the same cycle.
- Heading step table (dx,dy), each component multiplied by speed:
  - 0(0,-4), 1(+1,-3), 2(+2,-2), 3(+3,-1), 4(+4,0), 5(+3,+1), 6(+2,+2), 7(+1,+3)
  - 8(0,+4), 9(-1,+3), 10(-2,+2), 11(-3,+1), 12(-4,0), 13(-3,-1), 14(-2,-2), 15(-1,-3)
- Arithmetic: next coordinate computed signed at COORD_W+2 bits. An underflow below 0 is a crossing, never a wrap.
- Bounds are scaled by << FRAC_BITS. Reaching a bound exactly is legal; only strictly crossing it triggers an event.
- move in PLAY, registered with 1-cycle latency:
  - Heading used this cycle = dir_in if dir_load is high, else dir.
  - y crosses Y_MIN or Y_MAX: y clamped to that bound, heading -> (8-d) mod 16, bounce pulse.
  - x crosses X_MIN or X_MAX: x clamped, y updated and clamped, miss_l or miss_r pulse, in_play = 0, state OUT.
  - x crossing has priority: no bounce and no heading change on that cycle.
  - Otherwise x and y take the next values.
- dir_load without move in PLAY: dir = dir_in, no position change.
- move, dir_load, or both in IDLE/OUT: ignored.
- speed = 0: move leaves the position unchanged.
- rst mid-rally: immediate return to reset values; pulses cleared.

Optional Feature:
BALL_SPEEDUP_EN
- Defined: each accepted dir_load in PLAY increments speed by 1, saturating at 2^SPEED_W-1. Speed reverts to speed_in at serve.
- Undefined: speed stays constant for the whole rally.

Test Plan:
- Reset: rst high 2 cycles -> x=1280, y=960, dir=0, in_play=0, no pulses.
- Serve dir=4, speed=1, then 10 moves -> x=1320, y=960, in_play=1, no pulses.
- Top bounce: serve dir=0, speed=2:
  - After 115 moves -> y=40, dir=0, no bounce.
  - Move 116 -> y=40, dir=8, bounce for 1 cycle.
  - Next move -> y=48.
- Right miss: serve dir=4, speed=4:
  - After 77 moves -> x=2512.
  - Move 78 -> x=2520, miss_r for 1 cycle, in_play=0.
  - Further moves -> no change.
  - New serve -> x=1280.
- Simultaneous events:
  - In PLAY, move with dir_load and dir_in=12, speed 1 -> x decreases by 4.
  - serve with move in the same cycle -> centre position, no step.
- BALL_SPEEDUP_EN: serve speed=6, 3 dir_loads -> speed 7 (saturated); a dir=4 move then advances x by 28. Without the macro, the same sequence advances x by 24.
